// File: rtl/cp0_exc_unit.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_unit
// Description : Coprocessor-0 exception/interrupt unit for a 5-stage MIPS
//               pipeline, located at the M stage. It decides whether to trap
//               and records SR/Cause/EPC, with delay-slot correction of
//               Cause.BD and EPC. It also services mtc0, mfc0 and eret.
// Ports       : clk          - rising-edge clock
//               reset        - asynchronous, active-low reset
//               pc_in        - PC of the M-stage instruction
//               bd_in        - M-stage instruction is in a branch delay slot
//               exc_code_in  - exception code of M-stage instruction, 0 = none
//               hw_int       - level-sensitive hardware interrupt lines
//               we/addr/wdata- mtc0 write port (addr is also the mfc0 index)
//               eret         - eret in M stage
//               badvaddr_in  - faulting data address (CP0_BADVADDR_EN only)
//               rdata        - mfc0 read data, combinational on addr
//               epc_out      - current EPC, used as the eret target
//               req          - trap request: flush and redirect to handler_pc
//               handler_pc   - constant exception vector
// Options     : CP0_BADVADDR_EN adds the BadVAddr register (reg 8) and the
//               badvaddr_in port.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_unit #(
    parameter logic [31:0] PRID         = 32'h4D49_5053,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic        eret,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] badvaddr_in,
`endif
    output logic [31:0] rdata,
    output logic [31:0] epc_out,
    output logic        req,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] c_reg_badvaddr = 5'd8;
    localparam logic [4:0] c_reg_sr       = 5'd12;
    localparam logic [4:0] c_reg_cause    = 5'd13;
    localparam logic [4:0] c_reg_epc      = 5'd14;
    localparam logic [4:0] c_reg_prid     = 5'd15;

    // Architectural state; only implemented bits are stored.
    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:2] r_epc;

    logic        w_int_pend;
    logic        w_exc_pend;
    logic        w_req;
    logic [31:0] w_trap_pc;
    logic        w_unused;

    assign w_int_pend = (|(hw_int & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_pend = (exc_code_in != 5'd0) & ~r_sr_exl;
    // Gated by reset so no trap is requested while the unit is held in reset,
    // even if a stale exception code is present on the input.
    assign w_req      = (w_int_pend | w_exc_pend) & reset;

    // A delay-slot instruction restarts at its branch; wraps modulo 2^32.
    assign w_trap_pc  = bd_in ? (pc_in - 32'd4) : pc_in;
    assign w_unused   = ^w_trap_pc[1:0];

    assign req        = w_req;
    assign epc_out    = {r_epc, 2'b00};
    assign handler_pc = HANDLER_ADDR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr_im     <= '0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
        end else begin
            r_cause_ip <= hw_int;
            if (w_req) begin
                // Trap capture wins over both eret and mtc0 in this cycle.
                r_sr_exl    <= 1'b1;
                r_cause_bd  <= bd_in;
                r_cause_exc <= w_int_pend ? 5'd0 : exc_code_in;
                r_epc       <= w_trap_pc[31:2];
            end else begin
                if (we && (addr == c_reg_sr)) begin
                    r_sr_im  <= wdata[15:10];
                    r_sr_exl <= wdata[1];
                    r_sr_ie  <= wdata[0];
                end
                if (we && (addr == c_reg_epc)) begin
                    r_epc <= wdata[31:2];
                end
                // Placed after the SR write so eret overrides the EXL bit.
                if (eret) begin
                    r_sr_exl <= 1'b0;
                end
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] r_badvaddr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_badvaddr <= '0;
        end else if (w_req && !w_int_pend &&
                     ((exc_code_in == 5'd4) || (exc_code_in == 5'd5))) begin
            r_badvaddr <= badvaddr_in;
        end
    end
`endif

    // mfc0 reads the registered value: a same-cycle mtc0 is not forwarded.
    always_comb begin
        rdata = '0;
        case (addr)
            c_reg_sr:    rdata = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
            c_reg_cause: rdata = {r_cause_bd, 15'd0, r_cause_ip, 3'd0,
                                  r_cause_exc, 2'b00};
            c_reg_epc:   rdata = {r_epc, 2'b00};
            c_reg_prid:  rdata = PRID;
`ifdef CP0_BADVADDR_EN
            c_reg_badvaddr: rdata = r_badvaddr;
`else
            c_reg_badvaddr: rdata = '0;
`endif
            default:     rdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_cp0_exc_unit
// Description : Directed scoreboard bench for cp0_exc_unit. Expectations are
//               queued while stimulus is applied and compared between edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_unit;

    localparam logic [31:0] PRID         = 32'h4D49_5053;
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    localparam int c_k_reg = 0;
    localparam int c_k_req = 1;
    localparam int c_k_epc = 2;
    localparam int c_k_hpc = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic [31:0] badvaddr_in;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic        req;
    logic [31:0] handler_pc;

    typedef struct {
        string       tag;
        int          kind;
        logic [4:0]  a;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    cp0_exc_unit #(.PRID(PRID), .HANDLER_ADDR(HANDLER_ADDR)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .eret        (eret),
`ifdef CP0_BADVADDR_EN
        .badvaddr_in (badvaddr_in),
`endif
        .rdata       (rdata),
        .epc_out     (epc_out),
        .req         (req),
        .handler_pc  (handler_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int kind, input logic [4:0] a,
                        input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.a    = a;
        e.v    = v;
        sb.push_back(e);
    endtask

    // Pops every queued expectation and compares it against the live DUT.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        logic [4:0]  saved_addr;
        saved_addr = addr;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == c_k_reg) addr = e.a;
            #0.1;
            case (e.kind)
                c_k_reg: obs = rdata;
                c_k_req: obs = {31'd0, req};
                c_k_epc: obs = epc_out;
                default: obs = handler_pc;
            endcase
            n_assert++;
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
            end
        end
        addr = saved_addr;
        #0.1;
    endtask

    initial begin
        reset = 1'b0; pc_in = '0; bd_in = 1'b0; exc_code_in = 5'd3;
        hw_int = '0; we = 1'b0; addr = '0; wdata = '0; eret = 1'b0;
        badvaddr_in = '0;
        #2;
        // Reset state; a pending exception code must not raise req in reset.
        push("rst_sr",    c_k_reg, 5'd12, 32'h0);
        push("rst_cause", c_k_reg, 5'd13, 32'h0);
        push("rst_epc",   c_k_reg, 5'd14, 32'h0);
        push("rst_prid",  c_k_reg, 5'd15, PRID);
        push("rst_req",   c_k_req, 5'd0,  32'h0);
        push("handler",   c_k_hpc, 5'd0,  HANDLER_ADDR);
        drain();
        tick();
        reset = 1'b1; exc_code_in = 5'd0;
        tick();

        // Mid-run reset after SR and EPC were written.
        we = 1'b1; addr = 5'd14; wdata = 32'h0000_0100;
        tick();
        addr = 5'd12; wdata = 32'h0000_FC03;
        tick();
        we = 1'b0;
        push("sr_written",  c_k_reg, 5'd12, 32'h0000_FC03);
        push("epc_written", c_k_reg, 5'd14, 32'h0000_0100);
        drain();
        #2;
        reset = 1'b0; exc_code_in = 5'd5;
        #1;
        push("async_rst_sr",  c_k_reg, 5'd12, 32'h0);
        push("async_rst_epc", c_k_reg, 5'd14, 32'h0);
        push("async_rst_req", c_k_req, 5'd0,  32'h0);
        drain();
        tick();
        reset = 1'b1; exc_code_in = 5'd0;
        tick();
        push("post_rst_sr",  c_k_reg, 5'd12, 32'h0);
        push("post_rst_epc", c_k_reg, 5'd14, 32'h0);
        drain();

        // Delay-slot exception.
        pc_in = 32'h0000_3010; bd_in = 1'b1; exc_code_in = 5'd10;
        push("ds_req", c_k_req, 5'd0, 32'h1);
        drain();
        tick();
        push("ds_epc",     c_k_reg, 5'd14, 32'h0000_300C);
        push("ds_cause",   c_k_reg, 5'd13, 32'h8000_0028);
        push("ds_sr",      c_k_reg, 5'd12, 32'h0000_0002);
        push("ds_masked",  c_k_req, 5'd0,  32'h0);
        push("ds_epc_out", c_k_epc, 5'd0,  32'h0000_300C);
        drain();
        exc_code_in = 5'd0; bd_in = 1'b0;

        // Leave the handler, then enable IM[0] with IE.
        eret = 1'b1;
        tick();
        eret = 1'b0; we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
        tick();
        we = 1'b0;

        // Interrupt has priority over a simultaneous exception.
        hw_int = 6'b000001; exc_code_in = 5'd12; pc_in = 32'h0000_3020;
        push("iv_req", c_k_req, 5'd0, 32'h1);
        drain();
        tick();
        exc_code_in = 5'd0;
        push("iv_cause", c_k_reg, 5'd13, 32'h0000_0400);
        push("iv_epc",   c_k_reg, 5'd14, 32'h0000_3020);
        push("iv_sr",    c_k_reg, 5'd12, 32'h0000_0403);
        drain();

        // EXL masks every interrupt line; eret re-enables.
        hw_int = 6'h3F;
        push("exl_mask", c_k_req, 5'd0, 32'h0);
        drain();
        eret = 1'b1;
        push("exl_mask_eret", c_k_req, 5'd0, 32'h0);
        drain();
        tick();
        eret = 1'b0;
        push("eret_sr",      c_k_reg, 5'd12, 32'h0000_0401);
        push("eret_req",     c_k_req, 5'd0,  32'h1);
        push("eret_epc_out", c_k_epc, 5'd0,  32'h0000_3020);
        push("ip_follow",    c_k_reg, 5'd13, 32'h0000_FC00);
        drain();

        // Trap beats a same-cycle EPC write.
        pc_in = 32'h0000_3000;
        we = 1'b1; addr = 5'd14; wdata = 32'h1234_5677;
        tick();
        we = 1'b0;
        push("col_epc", c_k_reg, 5'd14, 32'h0000_3000);
        drain();

        // Write lands when no trap; same-cycle read returns old value.
        hw_int = '0;
        we = 1'b1; addr = 5'd14; wdata = 32'h1234_5677;
        push("col_req0",  c_k_req, 5'd0,  32'h0);
        push("no_fwd",    c_k_reg, 5'd14, 32'h0000_3000);
        drain();
        tick();
        push("wr_epc",     c_k_reg, 5'd14, 32'h1234_5674);
        push("wr_epc_out", c_k_epc, 5'd0,  32'h1234_5674);
        drain();

        // SR write with eret: EXL cleared, other fields land.
        addr = 5'd12; wdata = 32'h0000_0003; eret = 1'b1;
        tick();
        eret = 1'b0;
        push("sr_eret", c_k_reg, 5'd12, 32'h0000_0001);
        drain();

        // Read-only and unmapped writes are ignored.
        addr = 5'd13; wdata = 32'hFFFF_FFFF;
        tick();
        addr = 5'd15;
        tick();
        addr = 5'd8;
        tick();
        we = 1'b0;
        push("cause_ro", c_k_reg, 5'd13, 32'h0);
        push("prid_ro",  c_k_reg, 5'd15, PRID);
        push("unmapped", c_k_reg, 5'd3,  32'h0);
        push("reg8_idle", c_k_reg, 5'd8, 32'h0);
        drain();

        // PC wrap on delay-slot address error.
        pc_in = 32'h0; bd_in = 1'b1; exc_code_in = 5'd4;
        badvaddr_in = 32'h0000_0005;
        push("wrap_req", c_k_req, 5'd0, 32'h1);
        drain();
        tick();
        exc_code_in = 5'd0; bd_in = 1'b0;
        push("wrap_epc",   c_k_reg, 5'd14, 32'hFFFF_FFFC);
        push("wrap_cause", c_k_reg, 5'd13, 32'h8000_0010);
`ifdef CP0_BADVADDR_EN
        push("badvaddr",   c_k_reg, 5'd8,  32'h0000_0005);
`else
        push("reg8_zero",  c_k_reg, 5'd8,  32'h0);
`endif
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
